// File: rtl/regfile_mp.sv
// Multi-port register file with optional zero register and write-to-read bypass,
// plus a per-register busy scoreboard with an incrementally maintained occupancy count.
module regfile_mp #(
  parameter int DATA_W    = 64,
  parameter int REG_COUNT = 32,
  parameter int RD_PORTS  = 2,
  parameter int WR_PORTS  = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  localparam int ADDR_W   = $clog2(REG_COUNT),
  localparam int CNT_W    = $clog2(REG_COUNT + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WR_PORTS-1:0]          wr_en,
  input  logic [WR_PORTS*ADDR_W-1:0]   wr_addr,
  input  logic [WR_PORTS*DATA_W-1:0]   wr_data,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_busy,
  input  logic                         sb_set_en,
  input  logic [ADDR_W-1:0]            sb_set_addr,
  output logic [REG_COUNT-1:0]         busy_vec,
  output logic [CNT_W-1:0]             busy_count
);

  logic [DATA_W-1:0]    regs_q [REG_COUNT];
  logic [DATA_W-1:0]    regs_d [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic [REG_COUNT-1:0] clr_vec, set_vec;
  logic [CNT_W-1:0]     count_q, count_d, dec_cnt;
  logic                 inc;
  logic [ADDR_W-1:0]    ra;
  logic [DATA_W-1:0]    rv;

  // Ascending port order makes the highest-numbered port win on an address conflict.
  always_comb begin
    regs_d  = regs_q;
    clr_vec = '0;
    for (int p = 0; p < WR_PORTS; p++) begin
      if (wr_en[p]) begin
        clr_vec[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b1;
        regs_d[wr_addr[p*ADDR_W +: ADDR_W]]  = wr_data[p*DATA_W +: DATA_W];
      end
    end
    if (ZERO_REG != 0) begin
      regs_d[0]  = '0;
      clr_vec[0] = 1'b0;
    end
  end

  always_comb begin
    set_vec = '0;
    if (sb_set_en) set_vec[sb_set_addr] = 1'b1;
    if (ZERO_REG != 0) set_vec[0] = 1'b0;
    busy_d = (busy_q & ~clr_vec) | set_vec;
    inc    = |(set_vec & ~busy_q);
    // A register hit by several write ports still drops only once.
    dec_cnt = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (busy_q[i] && clr_vec[i] && !set_vec[i]) dec_cnt = dec_cnt + CNT_W'(1);
    end
    count_d = count_q + CNT_W'(inc) - dec_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= regs_d[i];
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rv      = '0;
    for (int r = 0; r < RD_PORTS; r++) begin
      ra = rd_addr[r*ADDR_W +: ADDR_W];
      rv = regs_q[ra];
      if (BYPASS != 0) begin
        for (int p = 0; p < WR_PORTS; p++) begin
          if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ra)) rv = wr_data[p*DATA_W +: DATA_W];
        end
      end
      if ((ZERO_REG != 0) && (ra == '0)) rv = '0;
      rd_data[r*DATA_W +: DATA_W] = rv;
      rd_busy[r] = busy_q[ra];
    end
    // Reads are forced quiet for the whole reset window, not just after the flops clear.
    if (rst) begin
      rd_data = '0;
      rd_busy = '0;
    end
  end

  assign busy_vec   = busy_q;
  assign busy_count = count_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance (zero reg, bypass) and a plain instance
// (no zero reg, no bypass) share stimulus and are checked against an array model.
module tb_regfile_mp;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int RC = 32;

  logic            clk;
  logic            rst;
  logic [1:0]      wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic [2*AW-1:0] rd_addr;
  logic            sb_set_en;
  logic [AW-1:0]   sb_set_addr;

  logic [2*DW-1:0] rdd [2];
  logic [1:0]      rdb [2];
  logic [RC-1:0]   bv  [2];
  logic [5:0]      bc  [2];

  logic [DW-1:0] m_mem  [2][RC];
  bit            m_busy [2][RC];

  int tests_run = 0;
  int fails = 0;

  regfile_mp u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rdd[0]), .rd_busy(rdb[0]),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .busy_vec(bv[0]), .busy_count(bc[0])
  );

  regfile_mp #(.ZERO_REG(0), .BYPASS(0)) u_alt (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rdd[1]), .rd_busy(rdb[1]),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .busy_vec(bv[1]), .busy_count(bc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < RC; a++) begin
        m_mem[i][a]  = '0;
        m_busy[i][a] = 1'b0;
      end
  endtask

  // Instance 0 has the zero register and bypass; instance 1 has neither.
  task automatic model_tick();
    logic [AW-1:0] a;
    if (rst) return;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        a = wr_addr[p*AW +: AW];
        if (wr_en[p]) begin
          m_busy[i][a] = 1'b0;
          if (!(i == 0 && a == 0)) m_mem[i][a] = wr_data[p*DW +: DW];
        end
      end
      if (sb_set_en && !(i == 0 && sb_set_addr == 0)) m_busy[i][sb_set_addr] = 1'b1;
    end
  endtask

  function automatic logic [63:0] exp_rd(input int i, input logic [AW-1:0] a);
    logic [63:0] v;
    v = m_mem[i][a];
    if (i == 0)
      for (int p = 0; p < 2; p++)
        if (wr_en[p] && wr_addr[p*AW +: AW] == a) v = wr_data[p*DW +: DW];
    if (i == 0 && a == 0) v = '0;
    if (rst) v = '0;
    return v;
  endfunction

  task automatic check_all();
    logic [AW-1:0] a;
    logic [RC-1:0] ev;
    int            ec;
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 2; r++) begin
        a = rd_addr[r*AW +: AW];
        chk($sformatf("rd_data i%0d r%0d a%0d", i, r, a), rdd[i][r*DW +: DW], exp_rd(i, a));
        chk($sformatf("rd_busy i%0d r%0d a%0d", i, r, a), 64'(rdb[i][r]),
            64'((rst == 1'b0) && m_busy[i][a]));
      end
      ev = '0;
      ec = 0;
      for (int k = 0; k < RC; k++) begin
        ev[k] = m_busy[i][k];
        ec += int'(m_busy[i][k]);
      end
      chk($sformatf("busy_vec i%0d", i), 64'(bv[i]), 64'(ev));
      chk($sformatf("busy_count i%0d", i), 64'(bc[i]), 64'(ec));
    end
  endtask

  task automatic drive(input logic [1:0] we, input logic [AW-1:0] a0, input logic [63:0] d0,
                       input logic [AW-1:0] a1, input logic [63:0] d1,
                       input logic se, input logic [AW-1:0] sa,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    wr_en       = we;
    wr_addr     = {a1, a0};
    wr_data     = {d1, d0};
    sb_set_en   = se;
    sb_set_addr = sa;
    rd_addr     = {r1, r0};
  endtask

  task automatic half();
    @(negedge clk);
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);
    model_reset();
    half();
    chk("reset busy_count", 64'(bc[0]), 64'd0);
    tick();
    rst = 1'b0;

    // Write address 0 through port 0.
    drive(2'b01, 0, 64'hDEADBEEFCAFEBABE, 0, 0, 1'b0, 0, 0, 0);
    half();
    chk("zero reg bypass", rdd[0][63:0], 64'h0);
    tick();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);
    half();
    chk("zero reg dropped", rdd[0][63:0], 64'h0);
    chk("no zero reg write", rdd[1][63:0], 64'hDEADBEEFCAFEBABE);
    tick();

    // Write-write conflict on address 5.
    drive(2'b11, 5, 64'h11, 5, 64'h22, 1'b0, 0, 5, 5);
    half();
    chk("conflict bypass", rdd[0][63:0], 64'h22);
    chk("conflict no bypass", rdd[1][63:0], 64'h0);
    tick();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5, 0);
    half();
    chk("conflict winner i0", rdd[0][63:0], 64'h22);
    chk("conflict winner i1", rdd[1][63:0], 64'h22);
    tick();

    // Bypass versus old value on address 1.
    drive(2'b01, 1, 64'h0123456789ABCDEF, 0, 0, 1'b0, 0, 1, 5);
    half();
    chk("bypass new", rdd[0][63:0], 64'h0123456789ABCDEF);
    chk("no bypass old", rdd[1][63:0], 64'h0);
    tick();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 1, 5);
    half();
    chk("no bypass next", rdd[1][63:0], 64'h0123456789ABCDEF);
    tick();

    // Scoreboard sequence.
    drive(2'b00, 0, 0, 0, 0, 1'b1, 3, 3, 7); half(); tick();
    drive(2'b00, 0, 0, 0, 0, 1'b1, 7, 3, 7); half(); tick();
    drive(2'b01, 3, 64'h33, 0, 0, 1'b0, 0, 3, 7);
    half();
    chk("two set count", 64'(bc[0]), 64'd2);
    chk("two set vec", 64'(bv[0]), 64'h88);
    chk("rd_busy r1 a7", 64'(rdb[0][1]), 64'd1);
    tick();
    drive(2'b10, 0, 0, 7, 64'h77, 1'b1, 7, 3, 7);
    half();
    chk("after clear count", 64'(bc[0]), 64'd1);
    tick();
    drive(2'b00, 0, 0, 0, 0, 1'b1, 0, 0, 7);
    half();
    chk("set wins count", 64'(bc[0]), 64'd1);
    chk("set wins vec", 64'(bv[0]), 64'h80);
    tick();
    drive(2'b01, 0, 64'h5, 0, 0, 1'b0, 0, 0, 7);
    half();
    chk("zero set ignored", 64'(bv[0]), 64'h80);
    chk("plain set reg0", 64'(bv[1]), 64'h81);
    tick();
    drive(2'b00, 0, 0, 0, 0, 1'b1, 9, 9, 7); half(); tick();
    drive(2'b11, 9, 64'h91, 9, 64'h92, 1'b0, 0, 9, 7); half(); tick();
    drive(2'b00, 0, 0, 0, 0, 1'b1, 10, 9, 7);
    half();
    chk("dual clear one dec", 64'(bc[0]), 64'd1);
    tick();
    drive(2'b00, 0, 0, 0, 0, 1'b1, 11, 9, 7); half(); tick();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5, 1);
    half();
    chk("pre reset count", 64'(bc[0]), 64'd3);

    // Asynchronous reset between edges.
    rst = 1'b1;
    #1;
    model_reset();
    chk("async rst count", 64'(bc[0]), 64'd0);
    chk("async rst vec", 64'(bv[0]), 64'd0);
    chk("async rst rd0", rdd[0][63:0], 64'd0);
    chk("async rst rd1 alt", rdd[1][127:64], 64'd0);
    check_all();
    tick();
    rst = 1'b0;
    drive(2'b01, 4, 64'h44, 0, 0, 1'b1, 4, 4, 5);
    half();
    chk("post reset bypass", rdd[0][63:0], 64'h44);
    tick();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 4, 5);
    half();
    chk("post reset write", rdd[1][63:0], 64'h44);
    chk("post reset set", 64'(bc[1]), 64'd1);
    tick();

    // Random traffic; narrow address range half the time to force conflicts.
    for (int n = 0; n < 1000; n++) begin
      logic [AW-1:0] a0, a1, sa, r0, r1;
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      a0 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      a1 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      sa = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      r0 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      r1 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      drive(2'($urandom), a0, {$urandom, $urandom}, a1, {$urandom, $urandom},
            1'($urandom), sa, r0, r1);
      half();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file, the successor to the 1W/2R `regfile`. It adds configurable read and write port counts, an optional hardwired zero register, and optional write-to-read bypass. It also carries a per-register busy scoreboard with a registered occupancy counter. It sits between decode/issue, which reads operands and marks destinations busy, and writeback, which writes results and clears busy bits.

Parameters:
- DATA_W, 64, register width in bits.
- REG_COUNT, 32, number of architectural registers. Must be a power of 2 and ≥ 2. ADDR_W = $clog2(REG_COUNT) is a localparam.
- RD_PORTS, 2, number of read ports (1..8).
- WR_PORTS, 2, number of write ports (1..4).
- ZERO_REG, 1, when 1, register 0 always reads 0, ignores writes and is never busy.
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  WR_PORTS  per-port write enable.
- wr_addr  in  WR_PORTS*ADDR_W  port p address is bits [p*ADDR_W +: ADDR_W].
- wr_data  in  WR_PORTS*DATA_W  port p data is bits [p*DATA_W +: DATA_W].
- rd_addr  in  RD_PORTS*ADDR_W  packed per read port, same layout as wr_addr.
- rd_data  out  RD_PORTS*DATA_W  packed per read port, combinational.
- rd_busy  out  RD_PORTS  busy bit of the addressed register, combinational.
- sb_set_en  in  1  mark a destination register busy (issue).
- sb_set_addr  in  ADDR_W  register to mark busy.
- busy_vec  out  REG_COUNT  registered busy bits.
- busy_count  out  $clog2(REG_COUNT+1)  registered population count of busy_vec.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - All registers, busy_vec and busy_count go to 0.
  - While rst=1, writes and sets are ignored and rd_data and rd_busy read 0.
- Write:
  - On the rising clk edge, each port with wr_en=1 updates reg[wr_addr].
  - Write latency is 1 cycle: the new value is visible on the array the cycle after the edge.
- Write-write conflict: if two or more enabled ports target the same address, the highest-numbered port wins. No error is flagged.
- Read:
  - rd_data[r] is combinational from reg[rd_addr[r]].
  - With BYPASS=1, if an enabled write port matches rd_addr[r] in the same cycle, rd_data[r] returns that port's wr_data instead. Highest-numbered matching port wins.
  - With BYPASS=0, a same-cycle write is not forwarded; the read returns the old value.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0, including any bypass, and rd_busy=0.
  - A set of address 0 is ignored.
- Scoreboard, per register, at the clk edge:
  - next busy = (busy & ~cleared) | set.
  - cleared = any enabled write port addressing the register.
  - set = sb_set_en with sb_set_addr equal to the register.
  - If set and clear hit the same register in the same cycle, set wins and busy=1, because a new producer has issued.
  - rd_busy[r] reflects the registered busy_vec only; a same-cycle clear is not forwarded.
- busy_count:
  - A registered counter updated incrementally each cycle.
  - Increment by 1 if a set turns a 0 into a 1.
  - Decrement by the number of distinct registers cleared from 1 to 0.
  - Must always equal popcount(busy_vec). It never exceeds REG_COUNT (or REG_COUNT−1 with ZERO_REG=1) and never wraps below 0.
- Clears of non-busy registers are no-ops. Multiple write ports to one busy register count as one decrement.
- Reset asserted mid-cycle clears everything immediately. The first edge after deassertion behaves normally.

Test Plan:
- Reset, then write port0 addr 0 = 64'hDEADBEEFCAFEBABE -> rd_data reads 0 at addr 0 (ZERO_REG=1). With ZERO_REG=0 it reads DEADBEEFCAFEBABE the cycle after.
- Same cycle: port0 writes addr 5 = 64'h11, port1 writes addr 5 = 64'h22 -> reg5 = 64'h22. A bypass read of addr 5 in that cycle also returns 64'h22.
- BYPASS=1: write addr 1 = 64'h0123456789ABCDEF with rd_addr0=1 in the same cycle -> rd_data0 = 64'h0123456789ABCDEF combinationally. With BYPASS=0 it returns the old value 0 that cycle and the new value the next cycle.
- sb_set addr 3, then addr 7 on consecutive cycles -> busy_count = 2 and busy_vec bits 3 and 7 set. Then write addr 3 -> busy_count = 1. Set addr 7 and write addr 7 in the same cycle -> bit 7 stays 1 and busy_count stays 1.
- Assert rst asynchronously between edges with busy_count = 3 and nonzero registers -> all outputs are 0 immediately, with no clock edge needed.
- Random: 1000 cycles of random writes, sets and reads on all ports against a reference model -> rd_data, rd_busy, busy_vec and busy_count match every cycle, and busy_count == popcount(busy_vec).
